// File: rtl/cache_pkg.sv
// Shared definitions for the write-back data cache: controller state encoding,
// a constant log2 helper and the derived widths of the default geometry.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cacheState_t;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    while ((32'sd1 << result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LINES  = 32;
  localparam int DEF_WORDS  = 4;
  localparam int DEF_OFF_W  = clog2(DEF_WORDS);
  localparam int DEF_IDX_W  = clog2(DEF_LINES);
  localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W;
  localparam int DEF_BLK_W  = DEF_DATA_W * DEF_WORDS;
  localparam int DEF_BA_W   = DEF_ADDR_W - DEF_OFF_W;

endpackage

// File: rtl/cache_line_array.sv
// Valid/dirty/tag/data storage for a direct-mapped cache: combinational lookup,
// synchronous word write and block fill, and reset-time invalidation.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int WORDS  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [clog2(LINES)-1:0]          idx,
  input  logic [((clog2(WORDS) > 0) ? clog2(WORDS) : 1)-1:0] offset,
  output logic                             lineValid,
  output logic                             lineDirty,
  output logic [TAG_W-1:0]                 lineTag,
  output logic [DATA_W*WORDS-1:0]          lineBlock,
  input  logic                             wrEn,
  input  logic [DATA_W-1:0]                wrWord,
  input  logic                             fillEn,
  input  logic [TAG_W-1:0]                 fillTag,
  input  logic [DATA_W*WORDS-1:0]          fillBlock
);

  localparam int BLK_W = DATA_W * WORDS;

  logic [LINES-1:0] validR;
  logic [LINES-1:0] dirtyR;
  logic [TAG_W-1:0] tagR  [LINES];
  logic [BLK_W-1:0] dataR [LINES];

  assign lineValid = validR[idx];
  assign lineDirty = dirtyR[idx];
  assign lineTag   = tagR[idx];
  assign lineBlock = dataR[idx];

  // Line status bits: a fill leaves the line clean, a store marks it dirty.
  always_ff @(posedge clk) begin
    if (rst) begin
      validR <= '0;
      dirtyR <= '0;
    end else if (fillEn) begin
      validR[idx] <= 1'b1;
      dirtyR[idx] <= 1'b0;
    end else if (wrEn) begin
      dirtyR[idx] <= 1'b1;
    end
  end

  // Tag and data payload; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (fillEn) begin
      tagR[idx]  <= fillTag;
      dataR[idx] <= fillBlock;
    end else if (wrEn) begin
      dataR[idx][offset*DATA_W +: DATA_W] <= wrWord;
    end
  end

endmodule

// File: rtl/data_cache_wb.sv
// Direct-mapped write-back, write-allocate data cache between a single-cycle
// core and a block-wide memory with a req/ack handshake.
module data_cache_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LINES  = 32,
  parameter int WORDS  = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      MemRead,
  input  logic                                      MemWrite,
  input  logic [ADDR_W-1:0]                         WordAddress,
  input  logic [DATA_W-1:0]                         DataIn,
  output logic [DATA_W-1:0]                         DataOut,
  output logic                                      Stall,
  output logic                                      mem_req,
  output logic                                      mem_we,
  output logic [ADDR_W-clog2(WORDS)-1:0]            mem_addr,
  output logic [DATA_W*WORDS-1:0]                   mem_wdata,
  input  logic [DATA_W*WORDS-1:0]                   mem_rdata,
  input  logic                                      mem_ack
);

  localparam int OFF_W  = clog2(WORDS);
  localparam int IDX_W  = clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W  = DATA_W * WORDS;
  localparam int OFF_SW = (OFF_W > 0) ? OFF_W : 1;

  cacheState_t stateR, stateNext;

  logic [TAG_W-1:0]  reqTag;
  logic [IDX_W-1:0]  reqIdx;
  logic [OFF_SW-1:0] reqOff;
  logic              lineValid, lineDirty, hit, wrEn, fillEn;
  logic [TAG_W-1:0]  lineTag;
  logic [BLK_W-1:0]  lineBlock;

  assign reqTag = WordAddress[ADDR_W-1 -: TAG_W];
  assign reqIdx = WordAddress[OFF_W +: IDX_W];

  generate
    if (OFF_W > 0) begin : gOffset
      assign reqOff = WordAddress[OFF_SW-1:0];
    end else begin : gNoOffset
      assign reqOff = 1'b0;
    end
  endgenerate

  assign hit = lineValid && (lineTag == reqTag);

  cache_line_array #(
    .LINES  (LINES),
    .WORDS  (WORDS),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) uLines (
    .clk       (clk),
    .rst       (rst),
    .idx       (reqIdx),
    .offset    (reqOff),
    .lineValid (lineValid),
    .lineDirty (lineDirty),
    .lineTag   (lineTag),
    .lineBlock (lineBlock),
    .wrEn      (wrEn),
    .wrWord    (DataIn),
    .fillEn    (fillEn),
    .fillTag   (reqTag),
    .fillBlock (mem_rdata)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNext;
    end
  end

  // Next state, core-side stall/read data and memory-port muxing.
  always_comb begin
    stateNext = stateR;
    Stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    DataOut   = '0;
    wrEn      = 1'b0;
    fillEn    = 1'b0;
    if (rst) begin
      stateNext = IDLE;
    end else begin
      case (stateR)
        IDLE: begin
          if (MemRead || MemWrite) begin
            if (hit) begin
              if (MemWrite) begin
                wrEn = 1'b1;
              end else begin
                DataOut = lineBlock[reqOff*DATA_W +: DATA_W];
              end
            end else begin
              Stall     = 1'b1;
              stateNext = (lineValid && lineDirty) ? WRITEBACK : ALLOCATE;
            end
          end else begin
            Stall = 1'b0;
          end
        end
        WRITEBACK: begin
          Stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {lineTag, reqIdx};
          mem_wdata = lineBlock;
          if (mem_ack) begin
            stateNext = ALLOCATE;
          end else begin
            stateNext = WRITEBACK;
          end
        end
        ALLOCATE: begin
          Stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {reqTag, reqIdx};
          if (mem_ack) begin
            fillEn    = 1'b1;
            stateNext = IDLE;
          end else begin
            stateNext = ALLOCATE;
          end
        end
        default: begin
          Stall     = 1'b1;
          stateNext = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_wb.sv
// Scoreboard bench for data_cache_wb: directed scenarios plus random traffic,
// checked against an abstract cache/memory model kept in the bench.
module tb_data_cache_wb;

  typedef struct {
    logic [31:0] data;
    int          stall;
  } opExp_t;

  typedef struct {
    logic         we;
    logic [7:0]   addr;
    logic [127:0] wdata;
  } memTxn_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         MemRead = 1'b0, MemWrite = 1'b0;
  logic [9:0]   WordAddress = 10'd0;
  logic [31:0]  DataIn = 32'd0, DataOut;
  logic         Stall, mem_req, mem_we, mem_ack;
  logic [7:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = 128'd0;
  logic         modelAck = 1'b0, spuriousAck = 1'b0;

  int checks = 0;
  int failures = 0;
  int lat = 3;
  int ackCnt = 0;
  int stallCnt = 0;

  logic [127:0] devMem [256];
  logic [127:0] refMem [256];
  logic         refValid [32];
  logic         refDirty [32];
  logic [2:0]   refTag [32];
  logic [127:0] refData [32];
  opExp_t       expOps [$];
  memTxn_t      expMem [$];

  assign mem_ack = modelAck | spuriousAck;

  always #5 clk = ~clk;

  data_cache_wb dut (
    .clk         (clk),
    .rst         (rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .WordAddress (WordAddress),
    .DataIn      (DataIn),
    .DataOut     (DataOut),
    .Stall       (Stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Backing memory: acks each request lat cycles after it starts.
  always @(posedge clk) begin
    #2;
    if (rst || !mem_req) begin
      ackCnt = 0;
      modelAck = 1'b0;
    end else begin
      if (modelAck) ackCnt = 0;
      ackCnt++;
      modelAck = (ackCnt >= lat);
      if (modelAck) begin
        if (mem_we) devMem[mem_addr] = mem_wdata;
        else mem_rdata = devMem[mem_addr];
      end
    end
  end

  // Monitor: pops expectations whenever the DUT completes a memory or core transfer.
  always @(negedge clk) begin
    opExp_t  e;
    memTxn_t m;
    if (rst) begin
      stallCnt = 0;
      check("rstStall", {127'd0, Stall}, 128'd0);
      check("rstMemReq", {127'd0, mem_req}, 128'd0);
    end else begin
      if (mem_req && mem_ack) begin
        if (expMem.size() == 0) begin
          checks++; failures++;
          $display("FAIL memTxnUnexpected actual we=%0b addr=%h required=none", mem_we, mem_addr);
        end else begin
          m = expMem.pop_front();
          check("memWe", {127'd0, mem_we}, {127'd0, m.we});
          check("memAddr", {120'd0, mem_addr}, {120'd0, m.addr});
          if (m.we) check("memWdata", mem_wdata, m.wdata);
        end
      end
      if (MemRead || MemWrite) begin
        if (Stall) begin
          stallCnt++;
        end else begin
          if (expOps.size() == 0) begin
            checks++; failures++;
            $display("FAIL opUnexpected actual addr=%h required=none", WordAddress);
          end else begin
            e = expOps.pop_front();
            check("stallCycles", 128'(stallCnt), 128'(e.stall));
            check("dataOut", {96'd0, DataOut}, {96'd0, e.data});
          end
          stallCnt = 0;
        end
      end else begin
        check("idleStall", {127'd0, Stall}, 128'd0);
        check("idleMemReq", {127'd0, mem_req}, 128'd0);
        check("idleDataOut", {96'd0, DataOut}, 128'd0);
      end
    end
  end

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      refValid[i] = 1'b0;
      refDirty[i] = 1'b0;
    end
    expOps.delete();
    expMem.delete();
  endtask

  task automatic doReset();
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    modelReset();
  endtask

  task automatic idle(input int n);
    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue one load/store, update the reference cache and wait for acceptance.
  task automatic doOp(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
    opExp_t     e;
    logic [4:0] idx;
    logic [2:0] tg;
    logic [1:0] off;
    logic [7:0] ba;
    logic       accepted;
    idx = a[6:2]; tg = a[9:7]; off = a[1:0]; ba = {tg, idx};
    e.stall = 0;
    if (!(refValid[idx] && refTag[idx] == tg)) begin
      if (refValid[idx] && refDirty[idx]) begin
        expMem.push_back('{1'b1, {refTag[idx], idx}, refData[idx]});
        refMem[{refTag[idx], idx}] = refData[idx];
        e.stall += lat;
      end
      expMem.push_back('{1'b0, ba, 128'd0});
      refData[idx] = refMem[ba];
      refValid[idx] = 1'b1;
      refDirty[idx] = 1'b0;
      refTag[idx] = tg;
      e.stall += lat + 1;
    end
    if (wr) begin
      refData[idx][off*32 +: 32] = d;
      refDirty[idx] = 1'b1;
      e.data = 32'd0;
    end else begin
      e.data = refData[idx][off*32 +: 32];
    end
    expOps.push_back(e);
    MemRead = rd; MemWrite = wr; WordAddress = a; DataIn = d;
    accepted = 1'b0;
    for (int c = 0; c < 40 && !accepted; c++) begin
      @(negedge clk);
      accepted = !Stall;
      @(posedge clk); #1;
    end
    if (!accepted) begin
      checks++; failures++;
      $display("FAIL opTimeout actual=stalled required=accepted addr=%h", a);
    end
  endtask

  initial begin
    logic [127:0] w;
    logic [2:0]   rtg;
    logic [1:0]   ridx, roff;
    int           sel;
    for (int i = 0; i < 256; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      devMem[i] = w;
      refMem[i] = w;
    end
    lat = 3;
    doReset();
    check("resetStall", {127'd0, Stall}, 128'd0);

    doOp(1'b1, 1'b0, 10'h001, 32'd0);
    idle(1);
    doReset();
    doOp(1'b0, 1'b1, 10'h001, 32'hFFFFAAAA);
    doOp(1'b1, 1'b0, 10'h001, 32'd0);
    doOp(1'b1, 1'b0, 10'h000, 32'd0);
    doOp(1'b0, 1'b1, 10'h001, 32'hCCCCBBBB);
    doOp(1'b1, 1'b0, 10'h001, 32'd0);
    doOp(1'b1, 1'b0, 10'h081, 32'd0);
    doOp(1'b1, 1'b0, 10'h001, 32'd0);
    idle(1);

    // Abandon an allocate in its second cycle with reset, then send a stray ack.
    MemRead = 1'b1; WordAddress = 10'h041;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; MemRead = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; spuriousAck = 1'b1;
    modelReset();
    @(negedge clk);
    check("abortMemReq", {127'd0, mem_req}, 128'd0);
    @(posedge clk); #1;
    spuriousAck = 1'b0;
    doOp(1'b1, 1'b0, 10'h001, 32'd0);
    doOp(1'b1, 1'b0, 10'h041, 32'd0);
    idle(1);

    for (int n = 0; n < 300; n++) begin
      lat = $urandom_range(1, 4);
      rtg = 3'($urandom_range(0, 7));
      ridx = 2'($urandom_range(0, 3));
      roff = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 2);
      doOp((sel != 1), (sel != 0), {rtg, 3'b000, ridx, roff}, $urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);
    check("opsDrained", 128'(expOps.size()), 128'd0);
    check("memDrained", 128'(expMem.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
